tdc_hw_accum: RTL and testbench
===============================

# tdc_hw_accum

Multi-channel measurement controller for the TDC array. It sits between N_CH `tdc_top` instances and the pin-mapped top level. On a start command it captures 2^LOG_SAMPLES valid Hamming-weight samples from one selected channel and reduces them to a sum, average, minimum or maximum. A per-measurement timeout guards against a dead channel, and the result is exposed through a byte-selectable readout that fits 8-bit output pins.

## Interface
- N, 64: delay-line length of each TDC. HW_W = $clog2(N)+1 is derived.
- N_CH, 4: number of TDC channels. CH_W = max(1,$clog2(N_CH)).
- LOG_SAMPLES, 4: log2 of the samples per measurement. ACC_W = HW_W+LOG_SAMPLES.
- TIMEOUT, 1024: idle cycles allowed between accepted samples before abort. Legal range is ≥1.
- clk  in  1  single clock; the only clock domain.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  global enable; low freezes all state, counters and outputs.
- start  in  1  one-cycle command pulse; honoured only in IDLE or DONE.
- ch_sel  in  CH_W  channel to measure; sampled on an accepted start.
- mode  in  2  reduction mode: 0 SUM, 1 AVG, 2 MIN, 3 MAX; sampled on an accepted start.
- hw_in  in  N_CH*HW_W  packed Hamming weights; channel c occupies [c*HW_W +: HW_W].
- hw_val  in  N_CH  per-channel sample-valid strobe, one cycle per sample.
- byte_sel  in  $clog2(ceil(ACC_W/8)) (min 1)  selects a result byte; byte 0 is the LSB.
- busy  out  1  high in ARM and ACCUM.
- done  out  1  high in DONE; held until the next accepted start or reset.
- timeout  out  1  set with done if the measurement aborted; cleared on accepted start.
- result  out  ACC_W  registered reduction result.
- sample_cnt  out  LOG_SAMPLES+1  number of samples accepted in the current or last measurement.
- byte_out  out  8  result byte at byte_sel, combinational; upper bits beyond ACC_W read 0; an out-of-range byte_sel reads 0.

## Operation
- States: IDLE, ARM, ACCUM, DONE.
- IDLE→ARM on start.
  - Latch ch_sel and mode.
  - Clear sample_cnt, timeout and the idle counter.
  - Preload the accumulator: all-ones for MIN, zero otherwise.
- ARM→ACCUM unconditionally after one cycle; no samples are accepted in ARM.
- ACCUM: when hw_val[ch] is high, accept hw_in[ch]:
  - SUM and AVG: acc += hw (ACC_W wide, cannot overflow).
  - MIN: acc = min(acc, hw).
  - MAX: acc = max(acc, hw).
  - sample_cnt increments and the idle counter clears.
- hw_val on non-selected channels is ignored.
- A channel whose ch_sel is ≥ N_CH never produces valids and therefore ends in timeout.
- ACCUM→DONE on the accept that brings sample_cnt to 2^LOG_SAMPLES. result loads:
  - SUM: acc.
  - AVG: acc>>LOG_SAMPLES, zero-extended.
  - MIN and MAX: acc, zero-extended.
- ACCUM→DONE with timeout=1 when the idle counter reaches TIMEOUT-1 with no valid that cycle. result then holds the partial reduction:
  - AVG: acc>>LOG_SAMPLES.
  - MIN with 0 samples: all-ones truncated to HW_W, zero-extended.
- When the completing sample and the idle-counter limit coincide, completion wins and timeout stays 0.
- DONE→ARM on start (restart with the newly sampled ch_sel and mode). While busy, start is ignored.
- en low: every register holds, a valid that cycle is dropped, and the idle counter does not advance.
- rst: the next state is IDLE and every output register is 0. This covers a reset asserted mid-measurement.

## Timing
- start accepted at edge t: busy=1 from t+1 (ARM), ACCUM from t+2. The earliest sample is accepted at edge t+2.
- Final sample accepted at edge k: done, result and the last sample_cnt update are visible after edge k. done=1 and busy=0 in the same cycle. Latency is 1 cycle from the last valid.
- Minimum measurement length is 2^LOG_SAMPLES+2 cycles from start.
- byte_out follows byte_sel and result combinationally, with zero cycle latency.
- Reset values: busy=0, done=0, timeout=0, result=0, sample_cnt=0, byte_out=0.

## Structure
- The shared package `tdc_pkg` holds:
  - the `tdc_mode_e` enum (SUM, AVG, MIN, MAX);
  - the `tdc_acc_state_e` enum (IDLE, ARM, ACCUM, DONE);
  - the HW_W and ACC_W width functions, which the top level also uses.
- One sub-module, `tdc_hw_reduce`: purely combinational next-accumulator given (mode, acc, hw). The FSM, counters and output registers stay in `tdc_hw_accum`.
- The top level maps byte_out to uo_out and the command and status bits to ui_in and uio.

## Test plan
All scenarios use defaults (N=64, ACC_W=11).
- SUM, ch 2, 16 valids of hw=32 on consecutive cycles → done after the 16th, result=512, byte_out[0]=0x00, byte_out[1]=0x02, sample_cnt=16, timeout=0.
- AVG, ch 0, samples 0,1,…,15 with gaps of 3 cycles → result=7 (sum 120>>4). Valids on ch 1 and ch 3 during the run have no effect.
- MIN then MAX back-to-back (start in DONE), ch 1, samples {40,12,63,…,30} → MIN=12, then MAX=63; busy reasserts 1 cycle after the second start.
- TIMEOUT=8, 3 samples of hw=5, then silence → done with timeout=1, sample_cnt=3, SUM result=15. Repeat with the 16th valid arriving on the limit cycle → timeout=0.
- start pulsed during ACCUM and en held low for 5 cycles with valids present → no restart, the dropped valids are not counted, and the measurement completes once en returns.
- rst asserted during ACCUM after 7 samples → next cycle all outputs 0 and state IDLE; a new start yields a clean 16-sample result.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the TDC measurement controller.
package tdc_pkg;

   typedef enum logic [1:0] {
      SUM = 2'd0,
      AVG = 2'd1,
      MIN = 2'd2,
      MAX = 2'd3
   } tdc_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      ACCUM = 2'd2,
      DONE  = 2'd3
   } tdc_acc_state_e;

   // Hamming weight of an N-tap line ranges 0..N, hence one extra bit.
   function automatic int unsigned hw_width(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

   function automatic int unsigned acc_width(input int unsigned n, input int unsigned log_samples);
      return hw_width(n) + log_samples;
   endfunction

   function automatic int unsigned ch_width(input int unsigned n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

   function automatic int unsigned bsel_width(input int unsigned acc_w);
      int unsigned nbytes;
      nbytes = (acc_w + 7) / 8;
      return (nbytes > 1) ? $clog2(nbytes) : 1;
   endfunction

endpackage

// File: rtl/tdc_hw_reduce.sv
// Combinational next-accumulator for one accepted Hamming-weight sample.
module tdc_hw_reduce
   import tdc_pkg::*;
#(
   parameter int unsigned HW_W  = 7,
   parameter int unsigned ACC_W = 11
)(
   input  logic [1:0]       mode_i,
   input  logic [ACC_W-1:0] acc_i,
   input  logic [HW_W-1:0]  hw_i,
   output logic [ACC_W-1:0] acc_o
);

   logic [ACC_W-1:0] hw_ext;

   always_comb begin
      hw_ext = ACC_W'(hw_i);
      acc_o  = acc_i + hw_ext;
      case (tdc_mode_e'(mode_i))
         MIN:     acc_o = (hw_ext < acc_i) ? hw_ext : acc_i;
         MAX:     acc_o = (hw_ext > acc_i) ? hw_ext : acc_i;
         default: acc_o = acc_i + hw_ext;
      endcase
   end

endmodule

// File: rtl/tdc_hw_accum.sv
// Multi-channel measurement controller: captures 2^LOG_SAMPLES samples from one
// TDC channel, reduces them, and exposes the result through a byte readout.
module tdc_hw_accum
   import tdc_pkg::*;
#(
   parameter int unsigned N           = 64,
   parameter int unsigned N_CH        = 4,
   parameter int unsigned LOG_SAMPLES = 4,
   parameter int unsigned TIMEOUT     = 1024
)(
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            en,
   input  logic                                            start,
   input  logic [ch_width(N_CH)-1:0]                       ch_sel,
   input  logic [1:0]                                      mode,
   input  logic [N_CH*hw_width(N)-1:0]                     hw_in,
   input  logic [N_CH-1:0]                                 hw_val,
   input  logic [bsel_width(acc_width(N,LOG_SAMPLES))-1:0] byte_sel,
   output logic                                            busy,
   output logic                                            done,
   output logic                                            timeout,
   output logic [acc_width(N,LOG_SAMPLES)-1:0]             result,
   output logic [LOG_SAMPLES:0]                            sample_cnt,
   output logic [7:0]                                      byte_out
);

   localparam int unsigned HW_W    = hw_width(N);
   localparam int unsigned ACC_W   = acc_width(N, LOG_SAMPLES);
   localparam int unsigned CH_W    = ch_width(N_CH);
   localparam int unsigned BSEL_W  = bsel_width(ACC_W);
   localparam int unsigned NBYTES  = (ACC_W + 7) / 8;
   localparam int unsigned PAD_W   = NBYTES * 8;
   localparam int unsigned SAMPLES = 1 << LOG_SAMPLES;
   localparam int unsigned IDLE_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned CNT_W   = LOG_SAMPLES + 1;

   tdc_acc_state_e   state_q;
   tdc_mode_e        mode_q;
   logic [CH_W-1:0]  ch_q;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [IDLE_W-1:0] idle_q;
   logic             busy_q;
   logic             done_q;
   logic             timeout_q;
   logic [ACC_W-1:0] result_q;
   logic [ACC_W-1:0] result_d;
   logic [CNT_W-1:0] sample_cnt_q;

   logic             sel_val;
   logic [HW_W-1:0]  sel_hw;
   logic [ACC_W-1:0] fin_src;
   logic             last_sample;
   logic             idle_limit;
   logic [PAD_W-1:0] res_pad;

   // An out-of-range channel matches no index, so it never yields a valid.
   always_comb begin
      sel_val = 1'b0;
      sel_hw  = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         if (ch_q == CH_W'(c)) begin
            sel_val = hw_val[c];
            sel_hw  = hw_in[c*HW_W +: HW_W];
         end
      end
   end

   tdc_hw_reduce #(
      .HW_W  (HW_W),
      .ACC_W (ACC_W)
   ) u_reduce (
      .mode_i (mode_q),
      .acc_i  (acc_q),
      .hw_i   (sel_hw),
      .acc_o  (acc_d)
   );

   // On the completing accept the freshly reduced value is finalised; on
   // timeout the partial accumulator is.
   always_comb begin
      fin_src = sel_val ? acc_d : acc_q;
      case (mode_q)
         AVG:      result_d = fin_src >> LOG_SAMPLES;
         MIN, MAX: result_d = ACC_W'(fin_src[HW_W-1:0]);
         default:  result_d = fin_src;
      endcase
   end

   assign last_sample = (sample_cnt_q == CNT_W'(SAMPLES - 1));
   assign idle_limit  = (idle_q == IDLE_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         mode_q       <= SUM;
         ch_q         <= '0;
         acc_q        <= '0;
         idle_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         result_q     <= '0;
         sample_cnt_q <= '0;
      end else if (en) begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q      <= ARM;
                  ch_q         <= ch_sel;
                  mode_q       <= tdc_mode_e'(mode);
                  acc_q        <= (tdc_mode_e'(mode) == MIN) ? '1 : '0;
                  idle_q       <= '0;
                  sample_cnt_q <= '0;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  timeout_q    <= 1'b0;
               end
            end
            ARM: state_q <= ACCUM;
            ACCUM: begin
               if (sel_val) begin
                  acc_q        <= acc_d;
                  sample_cnt_q <= sample_cnt_q + 1'b1;
                  idle_q       <= '0;
                  if (last_sample) begin
                     state_q  <= DONE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     result_q <= result_d;
                  end
               end else if (idle_limit) begin
                  state_q   <= DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b1;
                  result_q  <= result_d;
               end else begin
                  idle_q <= idle_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign res_pad = PAD_W'(result_q);

   always_comb begin
      byte_out = '0;
      for (int unsigned b = 0; b < NBYTES; b++) begin
         if (byte_sel == BSEL_W'(b)) byte_out = res_pad[b*8 +: 8];
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign timeout    = timeout_q;
   assign result     = result_q;
   assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_tdc_hw_accum.sv
// Randomised measurements against a sample-list reference model.
module tb_tdc_hw_accum;

   localparam int N_CH  = 4;
   localparam int HW_W  = 7;
   localparam int ACC_W = 11;
   localparam int NS    = 16;
   localparam int TO    = 8;

   logic              clk = 1'b0;
   logic              rst, en, start;
   logic [1:0]        ch_sel;
   logic [1:0]        mode;
   logic [N_CH*HW_W-1:0] hw_in;
   logic [N_CH-1:0]   hw_val;
   logic [0:0]        byte_sel;
   logic              busy, done, timeout;
   logic [ACC_W-1:0]  result;
   logic [4:0]        sample_cnt;
   logic [7:0]        byte_out;

   int n_vec = 0;
   int n_err = 0;

   // Expected externally visible status, maintained by the model.
   int m_done = 0, m_to = 0, m_cnt = 0, m_res = 0;

   tdc_hw_accum #(
      .N           (64),
      .N_CH        (N_CH),
      .LOG_SAMPLES (4),
      .TIMEOUT     (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .start      (start),
      .ch_sel     (ch_sel),
      .mode       (mode),
      .hw_in      (hw_in),
      .hw_val     (hw_val),
      .byte_sel   (byte_sel),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .result     (result),
      .sample_cnt (sample_cnt),
      .byte_out   (byte_out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bytes(input int exp_res);
      logic [31:0] r;
      r = exp_res;
      byte_sel = 1'b0;
      #1;
      check_eq("byte0", {24'd0, byte_out}, {24'd0, r[7:0]});
      byte_sel = 1'b1;
      #1;
      check_eq("byte1", {24'd0, byte_out}, {24'd0, r[15:8]});
      byte_sel = 1'b0;
   endtask

   task automatic check_status(input string tag);
      check_eq({tag, ".done"}, 32'(done), 32'(m_done));
      check_eq({tag, ".timeout"}, 32'(timeout), 32'(m_to));
      check_eq({tag, ".cnt"}, 32'(sample_cnt), 32'(m_cnt));
      check_eq({tag, ".result"}, 32'(result), 32'(m_res));
   endtask

   task automatic randomize_hw();
      for (int c = 0; c < N_CH; c++) hw_in[c*HW_W +: HW_W] = 7'($urandom_range(0, 64));
   endtask

   // profile 0: random valids; 1: channel dies after k_die samples;
   // 2: every sample arrives exactly on the idle-limit cycle.
   task automatic run_meas(input int profile, input int abort_at);
      int ch, md, n, quiet, k_die, sum, mn, mx, exp_res;
      bit fin, to_exp, v, e;
      int q[$];

      ch    = $urandom_range(0, N_CH - 1);
      md    = $urandom_range(0, 3);
      k_die = $urandom_range(0, NS - 1);

      // start with en low must be ignored
      en = 1'b0; start = 1'b1; ch_sel = 2'(ch); mode = 2'(md);
      hw_val = 4'($urandom); randomize_hw();
      tick();
      check_eq("en_low_start.busy", 32'(busy), 0);
      check_status("en_low_start");

      en = 1'b1;
      tick();
      start = 1'b0;
      m_done = 0; m_to = 0; m_cnt = 0;
      check_eq("start.busy", 32'(busy), 1);
      check_status("start");

      // ARM cycle: a valid on the selected channel is not accepted
      hw_val = '1; randomize_hw();
      tick();
      check_eq("arm.busy", 32'(busy), 1);
      check_eq("arm.cnt", 32'(sample_cnt), 0);

      n = 0; quiet = 0; fin = 0; to_exp = 0;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         e = ($urandom_range(0, 9) != 0);
         case (profile)
            0:       v = ($urandom_range(0, 2) == 0);
            1:       v = (n < k_die) && ($urandom_range(0, 1) == 1);
            default: v = (quiet == TO - 1);
         endcase
         hw_val = 4'($urandom);
         hw_val[ch] = v;
         randomize_hw();
         en = e;
         start = ($urandom_range(0, 9) == 0);
         tick();
         if (e) begin
            if (v) begin
               q.push_back(int'(hw_in[ch*HW_W +: HW_W]));
               n++;
               quiet = 0;
               if (n == NS) fin = 1;
            end else if (quiet == TO - 1) begin
               fin = 1;
               to_exp = 1;
            end else begin
               quiet++;
            end
         end
         check_eq("run.cnt", 32'(sample_cnt), 32'(n));
         check_eq("run.busy", 32'(busy), 32'(!fin));
         check_eq("run.done", 32'(done), 32'(fin));
         if (!fin && abort_at >= 0 && n >= abort_at) begin
            rst = 1'b1; en = 1'($urandom_range(0, 1)); start = 1'b0;
            tick();
            rst = 1'b0; en = 1'b1; hw_val = '0;
            m_done = 0; m_to = 0; m_cnt = 0; m_res = 0;
            check_eq("rst.busy", 32'(busy), 0);
            check_status("rst");
            check_bytes(0);
            return;
         end
      end
      en = 1'b1; start = 1'b0; hw_val = '0;
      if (!fin) begin
         check_eq("bound_expired", 0, 1);
         return;
      end

      sum = 0; mn = 127; mx = 0;
      foreach (q[i]) begin
         sum += q[i];
         if (q[i] < mn) mn = q[i];
         if (q[i] > mx) mx = q[i];
      end
      case (md)
         0:       exp_res = sum;
         1:       exp_res = sum / NS;
         2:       exp_res = mn;
         default: exp_res = mx;
      endcase
      m_done = 1; m_to = int'(to_exp); m_cnt = n; m_res = exp_res;
      check_status("end");
      check_bytes(exp_res);

      // DONE holds with start low regardless of activity
      for (int j = 0; j < $urandom_range(1, 3); j++) begin
         en = 1'($urandom_range(0, 1));
         hw_val = 4'($urandom); randomize_hw();
         tick();
         check_eq("hold.busy", 32'(busy), 0);
         check_status("hold");
      end
      en = 1'b1; hw_val = '0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; start = 1'b0; ch_sel = '0; mode = '0;
      hw_in = '0; hw_val = '0; byte_sel = '0;
      tick();
      tick();
      check_eq("reset.busy", 32'(busy), 0);
      check_status("reset");
      check_bytes(0);
      rst = 1'b0;

      for (int i = 0; i < 45; i++) begin
         run_meas(i % 3, (i % 9 == 4) ? $urandom_range(1, 10) : -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
